// File: rtl/ex_arb_queue_if.sv
// Writeback-message stream: seven payload fields plus a val/rdy handshake.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface ex_arb_queue_if #(
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
);
    logic [31:0]                 pc;
    logic [4:0]                  waddr;
    logic [31:0]                 wdata;
    logic                        wen;
    logic [p_seq_num_bits-1:0]   seq_num;
    logic [p_phys_addr_bits-1:0] preg;
    logic [p_phys_addr_bits-1:0] ppreg;
    logic                        val;
    logic                        rdy;

    modport master (
        output pc, waddr, wdata, wen, seq_num, preg, ppreg, val,
        input  rdy
    );

    modport slave (
        input  pc, waddr, wdata, wen, seq_num, preg, ppreg, val,
        output rdy
    );
endinterface

// File: rtl/ex_arb_queue.sv
// Execute-output buffer: one bypassable FIFO per execute pipe feeds a round-robin
// merge onto a single writeback stream. It supports flush and occupancy reporting.
module ex_arb_queue #(
    parameter int p_num_pipes      = 2,
    parameter int p_depth          = 8,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    ex_arb_queue_if.slave                            in [p_num_pipes],
    ex_arb_queue_if.master                           out,
    output logic [p_num_pipes*$clog2(p_depth+1)-1:0] occupancy
);
    localparam int MSG_W = 70 + p_seq_num_bits + 2*p_phys_addr_bits;
    localparam int OCC_W = $clog2(p_depth+1);
    localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int GNT_W = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

    typedef logic [MSG_W-1:0] msg_t;

    msg_t             in_msg   [p_num_pipes];
    msg_t             head_msg [p_num_pipes];
    msg_t             mem_q    [p_num_pipes][p_depth];
    logic [PTR_W-1:0] rd_ptr_q [p_num_pipes];
    logic [PTR_W-1:0] rd_ptr_d [p_num_pipes];
    logic [PTR_W-1:0] wr_ptr_q [p_num_pipes];
    logic [PTR_W-1:0] wr_ptr_d [p_num_pipes];
    logic [OCC_W-1:0] occ_q    [p_num_pipes];
    logic [OCC_W-1:0] occ_d    [p_num_pipes];

    logic [p_num_pipes-1:0] in_val;
    logic [p_num_pipes-1:0] in_rdy;
    logic [p_num_pipes-1:0] head_val;
    logic [p_num_pipes-1:0] push;
    logic [p_num_pipes-1:0] pop;

    logic [GNT_W-1:0] ptr_q;
    logic [GNT_W-1:0] ptr_d;
    logic [GNT_W-1:0] grant;
    logic             found;
    logic             out_val;
    msg_t             out_msg;

    function automatic logic [PTR_W-1:0] next_slot(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(p_depth-1)) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar g = 0; g < p_num_pipes; g++) begin : g_chan
        assign in_msg[g]   = {in[g].pc, in[g].waddr, in[g].wdata, in[g].wen,
                              in[g].seq_num, in[g].preg, in[g].ppreg};
        assign in_val[g]   = in[g].val;
        assign in[g].rdy   = in_rdy[g];
        assign head_val[g] = (occ_q[g] != '0) | in_val[g];
        // An empty channel presents its live input directly, so it has no latency.
        assign head_msg[g] = (occ_q[g] != '0) ? mem_q[g][rd_ptr_q[g]] : in_msg[g];
        assign occupancy[g*OCC_W +: OCC_W] = occ_q[g];
    end

    assign {out.pc, out.waddr, out.wdata, out.wen,
            out.seq_num, out.preg, out.ppreg} = out_msg;
    assign out.val = out_val;

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < p_num_pipes; k++) begin
            idx = (int'(ptr_q) + k) % p_num_pipes;
            if (!found && head_val[idx]) begin
                found = 1'b1;
                grant = GNT_W'(idx);
            end
        end
        out_val = found & !rst & !flush;
        out_msg = head_msg[grant];
    end

    always_comb begin
        logic gnt_i;
        logic full;
        logic empty;
        gnt_i    = 1'b0;
        full     = 1'b0;
        empty    = 1'b1;
        in_rdy   = '0;
        push     = '0;
        pop      = '0;
        occ_d    = occ_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        for (int i = 0; i < p_num_pipes; i++) begin
            gnt_i = found & (grant == GNT_W'(i));
            full  = (occ_q[i] == OCC_W'(p_depth));
            empty = (occ_q[i] == '0);
            if (rst)
                in_rdy[i] = 1'b0;
            else if (flush)
                in_rdy[i] = 1'b1;
            else
                in_rdy[i] = !full | (out.rdy & gnt_i & out_val);
            // A granted bypass leaves straight through and never lands in the FIFO.
            push[i] = in_val[i] & in_rdy[i] & !(empty & gnt_i & out.rdy) & !rst & !flush;
            pop[i]  = !empty & gnt_i & out.rdy & !rst & !flush;
            occ_d[i] = occ_q[i] + OCC_W'(push[i]) - OCC_W'(pop[i]);
            if (push[i]) wr_ptr_d[i] = next_slot(wr_ptr_q[i]);
            if (pop[i])  rd_ptr_d[i] = next_slot(rd_ptr_q[i]);
        end
        ptr_d = ptr_q;
        if (out_val && out.rdy)
            ptr_d = (grant == GNT_W'(p_num_pipes-1)) ? '0 : grant + GNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ptr_q <= '0;
            for (int i = 0; i < p_num_pipes; i++) begin
                occ_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            occ_q    <= occ_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // On a full channel that is also popping, the write lands in the slot being vacated.
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_num_pipes; i++)
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_msg[i];
    end
endmodule

// File: tb/tb_ex_arb_queue.sv
// Directed bench for ex_arb_queue (2 pipes, depth 2). Stimulus pushes expected pcs in
// output order, and a negedge monitor pops them and compares each transfer.
module tb_ex_arb_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [3:0] occupancy;

    ex_arb_queue_if #(.p_seq_num_bits(5), .p_phys_addr_bits(6)) in_if [2] ();
    ex_arb_queue_if #(.p_seq_num_bits(5), .p_phys_addr_bits(6)) out_if ();

    ex_arb_queue #(
        .p_num_pipes(2), .p_depth(2), .p_seq_num_bits(5), .p_phys_addr_bits(6)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in(in_if), .out(out_if), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [54:0] fields(input logic [31:0] pc);
        logic [4:0] s;
        s = pc[4:0] + 5'd3;
        return {pc[4:0], ~pc, pc[0], s, pc[5:0], ~pc[5:0]};
    endfunction

    task automatic drive(input int ch, input logic v, input logic [31:0] pc);
        if (ch == 0) begin
            in_if[0].val = v; in_if[0].pc = pc; in_if[0].waddr = pc[4:0];
            in_if[0].wdata = ~pc; in_if[0].wen = pc[0]; in_if[0].seq_num = pc[4:0] + 5'd3;
            in_if[0].preg = pc[5:0]; in_if[0].ppreg = ~pc[5:0];
        end else begin
            in_if[1].val = v; in_if[1].pc = pc; in_if[1].waddr = pc[4:0];
            in_if[1].wdata = ~pc; in_if[1].wen = pc[0]; in_if[1].seq_num = pc[4:0] + 5'd3;
            in_if[1].preg = pc[5:0]; in_if[1].ppreg = ~pc[5:0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0);
        step();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_if.val && out_if.rdy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out: got pc %0h, expected no transfer", out_if.pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pc", 64'(out_if.pc), 64'(mon_e));
                chk("out_fields", 64'({out_if.waddr, out_if.wdata, out_if.wen,
                    out_if.seq_num, out_if.preg, out_if.ppreg}), 64'(fields(mon_e)));
            end
        end
    end

    initial begin
        int i0, i1;
        logic r0, r1;
        rst = 1'b1; flush = 1'b0; out_if.rdy = 1'b0;
        drive(0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0);
        step(); #1;
        chk("rst_out_val", 64'(out_if.val), 64'd0);
        chk("rst_in0_rdy", 64'(in_if[0].rdy), 64'd0);
        chk("rst_in1_rdy", 64'(in_if[1].rdy), 64'd0);
        step(); rst = 1'b0; #1;
        chk("rst_occupancy", 64'(occupancy), 64'd0);

        // Bypass
        out_if.rdy = 1'b1;
        drive(0, 1'b1, 32'h100); exp_q.push_back(32'h100); #1;
        chk("t1_out_val", 64'(out_if.val), 64'd1);
        chk("t1_out_pc", 64'(out_if.pc), 64'h100);
        step(); drive(0, 1'b0, 32'h0); #1;
        chk("t1_occupancy", 64'(occupancy), 64'd0);

        // Contention
        do_reset(); out_if.rdy = 1'b1;
        drive(0, 1'b1, 32'h10); drive(1, 1'b1, 32'h20);
        exp_q.push_back(32'h10); exp_q.push_back(32'h20);
        step(); drive(0, 1'b0, 32'h0); drive(1, 1'b0, 32'h0); #1;
        chk("t2_occ1", 64'(occupancy[3:2]), 64'd1);
        chk("t2_out_pc_buf", 64'(out_if.pc), 64'h20);
        step(); #1;
        chk("t2_occ_drained", 64'(occupancy), 64'd0);

        // Backpressure and full channel
        do_reset(); out_if.rdy = 1'b0;
        drive(0, 1'b1, 32'hA); #1;
        chk("t3_rdy_empty", 64'(in_if[0].rdy), 64'd1);
        step(); drive(0, 1'b1, 32'hB);
        step(); drive(0, 1'b1, 32'hC); #1;
        chk("t3_occ0_full", 64'(occupancy[1:0]), 64'd2);
        chk("t3_rdy_full", 64'(in_if[0].rdy), 64'd0);
        out_if.rdy = 1'b1;
        exp_q.push_back(32'hA); exp_q.push_back(32'hB); exp_q.push_back(32'hC); #1;
        chk("t3_rdy_popping", 64'(in_if[0].rdy), 64'd1);
        step(); drive(0, 1'b0, 32'h0); #1;
        chk("t3_occ0_keep", 64'(occupancy[1:0]), 64'd2);
        step(); step(); #1;
        chk("t3_occ0_end", 64'(occupancy[1:0]), 64'd0);

        // Fairness: expected merge is a0 b0 a1 b1 a2 b2, then the drain a3 b3 a4 b4
        do_reset(); out_if.rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(32'h40 + 32'(k));
            exp_q.push_back(32'h60 + 32'(k));
        end
        i0 = 0; i1 = 0;
        for (int c = 0; c < 6; c++) begin
            drive(0, 1'b1, 32'h40 + 32'(i0));
            drive(1, 1'b1, 32'h60 + 32'(i1));
            #1;
            r0 = in_if[0].rdy; r1 = in_if[1].rdy;
            step();
            if (r0) i0++;
            if (r1) i1++;
        end
        drive(0, 1'b0, 32'h0); drive(1, 1'b0, 32'h0);
        chk("t4_accepted0", 64'(i0), 64'd5);
        chk("t4_accepted1", 64'(i1), 64'd5);
        for (int c = 0; c < 4; c++) step();
        #1;
        chk("t4_occ_drained", 64'(occupancy), 64'd0);

        // Flush
        do_reset(); out_if.rdy = 1'b0;
        drive(0, 1'b1, 32'h50); drive(1, 1'b1, 32'h60);
        step(); drive(0, 1'b1, 32'h51); drive(1, 1'b0, 32'h0);
        step(); drive(0, 1'b0, 32'h0); #1;
        chk("t5_occ_before", 64'(occupancy), 64'b0110);
        flush = 1'b1; out_if.rdy = 1'b1; drive(0, 1'b1, 32'h77); #1;
        chk("t5_flush_out_val", 64'(out_if.val), 64'd0);
        chk("t5_flush_in0_rdy", 64'(in_if[0].rdy), 64'd1);
        chk("t5_flush_in1_rdy", 64'(in_if[1].rdy), 64'd1);
        step(); flush = 1'b0; drive(0, 1'b0, 32'h0); #1;
        chk("t5_occ_after", 64'(occupancy), 64'd0);
        drive(0, 1'b1, 32'h80); drive(1, 1'b1, 32'h90);
        exp_q.push_back(32'h80); exp_q.push_back(32'h90); #1;
        chk("t5_ptr_zero", 64'(out_if.pc), 64'h80);
        step(); drive(0, 1'b0, 32'h0); drive(1, 1'b0, 32'h0);
        step(); #1;
        chk("t5_occ_drained", 64'(occupancy), 64'd0);

        // Reset mid-operation
        out_if.rdy = 1'b0;
        drive(0, 1'b1, 32'hC0); drive(1, 1'b1, 32'hD0);
        step(); drive(0, 1'b0, 32'h0); drive(1, 1'b1, 32'hD1);
        step(); drive(1, 1'b0, 32'h0); #1;
        chk("t6_occ_before", 64'(occupancy), 64'b1001);
        rst = 1'b1; out_if.rdy = 1'b1; drive(0, 1'b1, 32'hE0); #1;
        chk("t6_rst_out_val", 64'(out_if.val), 64'd0);
        chk("t6_rst_in0_rdy", 64'(in_if[0].rdy), 64'd0);
        chk("t6_rst_in1_rdy", 64'(in_if[1].rdy), 64'd0);
        step(); rst = 1'b0; #1;
        chk("t6_occ_after", 64'(occupancy), 64'd0);
        drive(0, 1'b1, 32'hF0); exp_q.push_back(32'hF0); #1;
        chk("t6_bypass_val", 64'(out_if.val), 64'd1);
        chk("t6_bypass_pc", 64'(out_if.pc), 64'hF0);
        step(); drive(0, 1'b0, 32'h0); #1;
        chk("t6_occ_end", 64'(occupancy), 64'd0);

        step(); step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
